// File: rtl/countdown_min_seg_ds_pkg.sv
// countdown_pkg: shared states, digit limits and preset clamping for the countdown timer
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd5;
  localparam logic [2:0] BLINK_TICKS = 3'd5;
  function automatic logic [3:0] clamp_u(input logic [3:0] v);
    return (v > UNITS_MAX) ? UNITS_MAX : v;
  endfunction
  function automatic logic [2:0] clamp_t(input logic [2:0] v);
    return (v > TENS_MAX) ? TENS_MAX : v;
  endfunction
endpackage

// File: rtl/countdown_min_seg_ds_rise_edge_det.sv
// rise_edge_det: one-cycle pulse on a rising edge of d
module rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic q;
  // previous sample of d, cleared by the active-low synchronous reset
  always_ff @(posedge clk)
    q <= !rst ? 1'b0 : d;
  assign pulse = d & ~q;
endmodule

// File: rtl/countdown_min_seg_ds.sv
// countdown_min_seg_ds: BCD mm:ss.d countdown timer; define COUNTDOWN_ALARM_BLINK_EN for a blinking alarm
module countdown_min_seg_ds
  import countdown_pkg::*;
#(
  parameter int TICK_CYCLES = 5000000,
  parameter int PRE_W = $clog2(TICK_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       stp_r,
  input  logic [3:0] pre_ds,
  input  logic [3:0] pre_s1,
  input  logic [2:0] pre_s2,
  input  logic [3:0] pre_m1,
  input  logic [2:0] pre_m2,
  output logic [3:0] cnt_ds,
  output logic [3:0] cnt_s1,
  output logic [2:0] cnt_s2,
  output logic [3:0] cnt_m1,
  output logic [2:0] cnt_m2,
  output logic       running,
  output logic       done,
  output logic       alarm
);
  state_t state, state_n;
  logic [PRE_W-1:0] pre, pre_n, pre_inc;
  logic [3:0] ds_n, s1_n, m1_n, dec_ds, dec_s1, dec_m1;
  logic [2:0] s2_n, m2_n, dec_s2, dec_m2;
  logic se, tick, zero, dec_zero, done_n, b0, b1, b2, b3;
`ifdef COUNTDOWN_ALARM_BLINK_EN
  logic [2:0] blink, blink_n;
  logic alarm_q, alarm_q_n;
`endif

  rise_edge_det u_se (.clk(clk), .rst(rst), .d(stp_r), .pulse(se));

  assign tick = pre == PRE_W'(TICK_CYCLES - 1);
  assign pre_inc = tick ? '0 : pre + PRE_W'(1);
  assign zero = {cnt_m2, cnt_m1, cnt_s2, cnt_s1, cnt_ds} == '0;
  assign b0 = cnt_ds == 4'd0;
  assign b1 = b0 & (cnt_s1 == 4'd0);
  assign b2 = b1 & (cnt_s2 == 3'd0);
  assign b3 = b2 & (cnt_m1 == 4'd0);
  assign dec_ds = b0 ? UNITS_MAX : cnt_ds - 4'd1;
  assign dec_s1 = b0 ? (cnt_s1 == 4'd0 ? UNITS_MAX : cnt_s1 - 4'd1) : cnt_s1;
  assign dec_s2 = b1 ? (cnt_s2 == 3'd0 ? TENS_MAX : cnt_s2 - 3'd1) : cnt_s2;
  assign dec_m1 = b2 ? (cnt_m1 == 4'd0 ? UNITS_MAX : cnt_m1 - 4'd1) : cnt_m1;
  assign dec_m2 = b3 ? cnt_m2 - 3'd1 : cnt_m2;
  assign dec_zero = {dec_m2, dec_m1, dec_s2, dec_s1, dec_ds} == '0;
  assign running = state == RUN;
`ifdef COUNTDOWN_ALARM_BLINK_EN
  assign alarm = (state == DONE) & alarm_q;
`else
  assign alarm = state == DONE;
`endif

  // state, prescaler and digit registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pre <= '0;
      {cnt_m2, cnt_m1, cnt_s2, cnt_s1, cnt_ds} <= '0;
      done <= 1'b0;
`ifdef COUNTDOWN_ALARM_BLINK_EN
      blink <= '0;
      alarm_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pre <= pre_n;
      {cnt_m2, cnt_m1, cnt_s2, cnt_s1, cnt_ds} <= {m2_n, m1_n, s2_n, s1_n, ds_n};
      done <= done_n;
`ifdef COUNTDOWN_ALARM_BLINK_EN
      blink <= blink_n;
      alarm_q <= alarm_q_n;
`endif
    end
  end

  // next state: load outside RUN has priority, otherwise start/pause and tick handling
  always_comb begin
    state_n = state;
    pre_n = pre;
    {m2_n, m1_n, s2_n, s1_n, ds_n} = {cnt_m2, cnt_m1, cnt_s2, cnt_s1, cnt_ds};
    done_n = 1'b0;
`ifdef COUNTDOWN_ALARM_BLINK_EN
    blink_n = blink;
    alarm_q_n = alarm_q;
`endif
    if (load && state != RUN) begin
      {m2_n, m1_n, s2_n, s1_n, ds_n} = {clamp_t(pre_m2), clamp_u(pre_m1), clamp_t(pre_s2), clamp_u(pre_s1), clamp_u(pre_ds)};
      pre_n = '0;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (se && !zero) begin
          state_n = RUN;
          pre_n = '0;
        end
        RUN: if (se) state_n = PAUSE;
        else begin
          pre_n = pre_inc;
          if (tick) begin
            {m2_n, m1_n, s2_n, s1_n, ds_n} = {dec_m2, dec_m1, dec_s2, dec_s1, dec_ds};
            if (dec_zero) begin
              state_n = DONE;
              done_n = 1'b1;
`ifdef COUNTDOWN_ALARM_BLINK_EN
              blink_n = '0;
              alarm_q_n = 1'b1;
`endif
            end
          end
        end
        PAUSE: if (se) state_n = RUN;
        default: begin
`ifdef COUNTDOWN_ALARM_BLINK_EN
          pre_n = pre_inc;
          if (tick) begin
            blink_n = (blink == BLINK_TICKS - 3'd1) ? 3'd0 : blink + 3'd1;
            alarm_q_n = (blink == BLINK_TICKS - 3'd1) ? ~alarm_q : alarm_q;
          end
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_countdown_min_seg_ds.sv
// tb_countdown_min_seg_ds: directed and random checks against a tenths-count reference model
module tb_countdown_min_seg_ds;
  localparam int TC = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0, rst = 1'b0, load = 1'b0, stp_r = 1'b0;
  logic [3:0] pre_ds = '0, pre_s1 = '0, pre_m1 = '0;
  logic [2:0] pre_s2 = '0, pre_m2 = '0;
  logic [3:0] cnt_ds, cnt_s1, cnt_m1;
  logic [2:0] cnt_s2, cnt_m2;
  logic running, done, alarm;
  logic [17:0] digs;
  logic [20:0] outs;

  int n_chk = 0, n_pass = 0;
  int rem = 0, phase = 0, mode = M_IDLE, dcyc = 0;
  bit prev_stp = 0, m_done = 0;

  countdown_min_seg_ds #(.TICK_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .load(load), .stp_r(stp_r),
    .pre_ds(pre_ds), .pre_s1(pre_s1), .pre_s2(pre_s2), .pre_m1(pre_m1), .pre_m2(pre_m2),
    .cnt_ds(cnt_ds), .cnt_s1(cnt_s1), .cnt_s2(cnt_s2), .cnt_m1(cnt_m1), .cnt_m2(cnt_m2),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  assign digs = {cnt_m2, cnt_m1, cnt_s2, cnt_s1, cnt_ds};
  assign outs = {digs, running, done, alarm};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
  endtask

  function automatic logic [17:0] dig(input int m2, m1, s2, s1, ds);
    return {3'(m2), 4'(m1), 3'(s2), 4'(s1), 4'(ds)};
  endfunction

  function automatic int preset_tenths();
    int ds, s1, s2, m1, m2;
    ds = pre_ds > 9 ? 9 : int'(pre_ds);
    s1 = pre_s1 > 9 ? 9 : int'(pre_s1);
    m1 = pre_m1 > 9 ? 9 : int'(pre_m1);
    s2 = pre_s2 > 5 ? 5 : int'(pre_s2);
    m2 = pre_m2 > 5 ? 5 : int'(pre_m2);
    return ((m2 * 10 + m1) * 60 + s2 * 10 + s1) * 10 + ds;
  endfunction

  function automatic logic [20:0] model_out();
    int m, s;
    bit al;
    m = rem / 600;
    s = (rem / 10) % 60;
`ifdef COUNTDOWN_ALARM_BLINK_EN
    al = (mode == M_DONE) && ((dcyc / (5 * TC)) % 2 == 0);
`else
    al = mode == M_DONE;
`endif
    return {dig(m / 10, m % 10, s / 10, s % 10, rem % 10), mode == M_RUN, m_done, al};
  endfunction

  task automatic model_update();
    bit se;
    if (!rst) begin
      rem = 0; phase = 0; mode = M_IDLE; prev_stp = 0; m_done = 0; dcyc = 0;
    end else begin
      se = stp_r && !prev_stp;
      prev_stp = stp_r;
      m_done = 0;
      if (load && mode != M_RUN) begin
        rem = preset_tenths(); phase = 0; mode = M_IDLE;
      end else if (mode == M_IDLE) begin
        if (se && rem > 0) begin mode = M_RUN; phase = 0; end
      end else if (mode == M_RUN) begin
        if (se) mode = M_PAUSE;
        else begin
          phase++;
          if (phase == TC) begin
            phase = 0;
            rem--;
            if (rem == 0) begin mode = M_DONE; m_done = 1; dcyc = 0; end
          end
        end
      end else if (mode == M_PAUSE) begin
        if (se) mode = M_RUN;
      end else dcyc++;
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic sp);
    rst = r; load = ld; stp_r = sp;
    @(posedge clk);
    model_update();
    #1;
    check("cyc", 32'(outs), 32'(model_out()));
  endtask

  task automatic set_pre(input int m2, m1, s2, s1, ds);
    pre_m2 = 3'(m2); pre_m1 = 4'(m1); pre_s2 = 3'(s2); pre_s1 = 4'(s1); pre_ds = 4'(ds);
  endtask

  initial begin
    int dn;
    step(0, 0, 0);
    step(0, 0, 0);
    check("reset", 32'(outs), 32'd0);

    set_pre(0, 0, 0, 1, 2);
    step(1, 1, 0);
    check("load_012", 32'(digs), 32'(dig(0, 0, 0, 1, 2)));
    step(1, 0, 1);
    check("start_run", 32'(running), 32'd1);
    dn = 0;
    for (int i = 0; i < 48; i++) begin
      step(1, 0, 0);
      if (i == 3) check("first_tick", 32'(digs), 32'(dig(0, 0, 0, 1, 1)));
      if (i == 11) check("wrap_ds", 32'(digs), 32'(dig(0, 0, 0, 0, 9)));
      if (done) dn++;
    end
    check("zero_digits", 32'(digs), 32'd0);
    check("alarm_on", 32'(alarm), 32'd1);
    check("run_off", 32'(running), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      if (done) dn++;
    end
    check("done_once", 32'(dn), 32'd1);

    set_pre(1, 0, 0, 0, 0);
    step(1, 1, 0);
    step(1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    check("borrow_all", 32'(digs), 32'(dig(0, 9, 5, 9, 9)));

    step(1, 0, 1);
    step(1, 0, 0);
    set_pre(6, 12, 7, 13, 15);
    step(1, 1, 0);
    check("clamp", 32'(digs), 32'(dig(5, 9, 5, 9, 9)));

    set_pre(0, 0, 0, 0, 5);
    step(1, 1, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    check("pause_hold", 32'(digs), 32'(dig(0, 0, 0, 0, 5)));
    check("pause_norun", 32'(running), 32'd0);
    step(1, 0, 1);
    step(1, 0, 0);
    check("resume_1", 32'(digs), 32'(dig(0, 0, 0, 0, 5)));
    step(1, 0, 0);
    check("resume_2", 32'(digs), 32'(dig(0, 0, 0, 0, 4)));

    step(1, 0, 1);
    step(1, 0, 0);
    set_pre(0, 0, 0, 0, 0);
    step(1, 1, 0);
    step(1, 0, 1);
    check("zero_start", 32'(running), 32'd0);
    step(1, 0, 0);
    set_pre(0, 0, 0, 0, 3);
    step(1, 1, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    set_pre(0, 1, 0, 2, 3);
    step(1, 1, 1);
    check("load_wins", 32'(digs), 32'(dig(0, 1, 0, 2, 3)));
    check("load_idle", 32'(running), 32'd0);
    step(1, 0, 0);

    set_pre(0, 3, 2, 7, 4);
    step(1, 1, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    check("mid_run", 32'(outs), 32'({dig(0, 3, 2, 7, 4), 3'b100}));
    step(0, 0, 0);
    check("rst_run", 32'(outs), 32'd0);

    set_pre(0, 0, 0, 0, 1);
    step(1, 1, 0);
    step(1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    check("done_1tick", 32'({done, alarm}), 32'd3);
    for (int i = 0; i < 19; i++) step(1, 0, 0);
    check("alarm_19", 32'(alarm), 32'd1);
    step(1, 0, 0);
`ifdef COUNTDOWN_ALARM_BLINK_EN
    check("blink_off", 32'(alarm), 32'd0);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    check("blink_on", 32'(alarm), 32'd1);
`else
    check("alarm_steady", 32'(alarm), 32'd1);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) set_pre(0, 0, 0, $urandom_range(0, 2), $urandom_range(0, 15));
      else set_pre($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15));
      step($urandom_range(0, 299) != 0, $urandom_range(0, 39) == 0,
           ($urandom_range(0, 7) == 0) ? ~stp_r : stp_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
